simon_block_serializer: RTL and testbench

Output stage directly downstream of the SIMON 128/256 cipher core. Captures each finished 128-bit block the core presents on its done/data outputs, acknowledges it with a one-cycle read strobe, buffers up to D blocks, and streams them out as W-bit words over a valid/ready interface with an end-of-block marker. Decouples the cipher from a slower or stalling consumer, so the core can start the next block while earlier results drain.

---
 rtl/simon_pkg.sv | 21 ++
 rtl/simon_block_fifo.sv | 66 ++++++
 rtl/simon_block_serializer.sv | 136 +++++++++++++
 tb/tb_simon_block_serializer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared defaults, types and helpers for the SIMON 128/256 output serializer.
package simon_pkg;

  localparam int SIMON_N   = 64;
  localparam int SIMON_W   = 32;
  localparam int SIMON_D   = 2;
  localparam int SIMON_WPB = (2 * SIMON_N) / SIMON_W;

  typedef logic [1:0][SIMON_N-1:0] simon_block_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Pointer/index width that stays legal when only one slot exists.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/simon_block_fifo.sv
// Circular D-entry buffer of cipher blocks; the head entry stays in place until popped.
module simon_block_fifo
  import simon_pkg::*;
#(
  parameter int BW = 2 * SIMON_N,
  parameter int D  = SIMON_D
) (
  input  logic          clk,
  input  logic          nR,
  input  logic          push,
  input  logic [BW-1:0] push_data,
  input  logic          pop,
  output logic [BW-1:0] head_data,
  output logic          empty,
  output logic          full
);

  localparam int PTR_W = clog2_min1(D);
  localparam int CNT_W = $clog2(D + 1);

  logic [BW-1:0]    mem [D];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(D - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= push_data;
    end
  end

  // A simultaneous push and pop moves both pointers and leaves the count alone.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        tail <= ptr_inc(tail);
      end
      if (pop_ok) begin
        head <= ptr_inc(head);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(D));

endmodule

// File: rtl/simon_block_serializer.sv
// Captures SIMON result blocks into a small buffer and streams them as W-bit words, MSW first.
// Define SIMON_SER_PARITY_EN to add the registered even-parity output wordPar.
module simon_block_serializer
  import simon_pkg::*;
#(
  parameter int N = SIMON_N,
  parameter int W = SIMON_W,
  parameter int D = SIMON_D
) (
  input  logic              clk,
  input  logic              nR,
  input  logic              doneData,
  input  logic [1:0][N-1:0] outData,
  output logic              readData,
  output logic [W-1:0]      wordOut,
  output logic              wordValid,
  input  logic              wordReady,
  output logic              wordLast,
`ifdef SIMON_SER_PARITY_EN
  output logic              wordPar,
`endif
  output logic              empty,
  output logic              full
);

  localparam int BW    = 2 * N;
  localparam int WPB   = BW / W;
  localparam int IDX_W = clog2_min1(WPB);

  ser_state_e       state;
  ser_state_e       next_state;
  logic             capture;
  logic             load;
  logic             advance;
  logic             pop;
  logic             last_word;
  logic [BW-1:0]    head_block;
  logic [BW-1:0]    shift_q;
  logic [BW-1:0]    shift_next;
  logic [IDX_W-1:0] idx_q;

  // The readData cycle masks doneData so a block is never taken twice.
  assign capture = doneData & ~readData & ~full;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      readData <= 1'b0;
    end else begin
      readData <= capture;
    end
  end

  simon_block_fifo #(
    .BW(BW),
    .D (D)
  ) u_fifo (
    .clk      (clk),
    .nR       (nR),
    .push     (capture),
    .push_data(outData),
    .pop      (pop),
    .head_data(head_block),
    .empty    (empty),
    .full     (full)
  );

  assign last_word = (idx_q == IDX_W'(WPB - 1));

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = SEND;
      SEND:    if (wordReady && last_word) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wordValid = 1'b0;
    wordLast  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: load = ~empty;
      SEND: begin
        wordValid = 1'b1;
        wordLast  = last_word;
        if (wordReady) begin
          pop     = last_word;
          advance = ~last_word;
        end
      end
      default: ;
    endcase
  end

  // The head block is copied out on load; the buffer slot is freed only after its last word.
  assign shift_next = shift_q << W;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      shift_q <= head_block;
      idx_q   <= '0;
    end else if (advance) begin
      shift_q <= shift_next;
      idx_q   <= idx_q + 1'b1;
    end
  end

  assign wordOut = shift_q[BW-1 -: W];

`ifdef SIMON_SER_PARITY_EN
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wordPar <= 1'b0;
    end else if (load) begin
      wordPar <= ^head_block[BW-1 -: W];
    end else if (advance) begin
      wordPar <= ^shift_next[BW-1 -: W];
    end
  end
`endif

endmodule

// File: tb/tb_simon_block_serializer.sv
// Self-checking bench: random blocks feed a queue model of expected words, occupancy and pulses.
// Define SIMON_SER_PARITY_EN to also check wordPar.
module tb_simon_block_serializer;

  localparam int N   = 64;
  localparam int W   = 32;
  localparam int D   = 2;
  localparam int BW  = 2 * N;
  localparam int WPB = BW / W;

  typedef struct packed {
    logic [W-1:0] word;
    logic         last;
  } exp_word_t;

  logic              clk = 1'b0;
  logic              nR = 1'b0;
  logic              doneData = 1'b0;
  logic [1:0][N-1:0] outData = '0;
  logic              readData;
  logic [W-1:0]      wordOut;
  logic              wordValid;
  logic              wordReady = 1'b0;
  logic              wordLast;
  logic              empty;
  logic              full;
`ifdef SIMON_SER_PARITY_EN
  logic              wordPar;
`endif

  int            total = 0;
  int            bad = 0;
  int            rd_count = 0;
  int            model_count = 0;
  bit            pending_pop = 0;
  bit            mid_block = 0;
  bit            prev_rd = 0;
  logic [BW-1:0] cur_blk = '0;
  exp_word_t     exp_q[$];

  simon_block_serializer dut (
    .clk      (clk),
    .nR       (nR),
    .doneData (doneData),
    .outData  (outData),
    .readData (readData),
    .wordOut  (wordOut),
    .wordValid(wordValid),
    .wordReady(wordReady),
    .wordLast (wordLast),
`ifdef SIMON_SER_PARITY_EN
    .wordPar  (wordPar),
`endif
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: every captured block expands into WPB expected words, MSW first.
  initial begin
    exp_word_t e;
    forever begin
      @(negedge clk);
      if (!nR) begin
        exp_q.delete();
        model_count = 0;
        pending_pop = 0;
        mid_block = 0;
        prev_rd = 0;
      end else begin
        if (pending_pop) begin
          model_count--;
          pending_pop = 0;
        end
        total++;
        if (readData && prev_rd) begin
          bad++;
          $display("[TB] FAIL rd_pulse: readData high two cycles in a row, required single-cycle pulse");
        end
        if (readData) begin
          rd_count++;
          model_count++;
          for (int i = 0; i < WPB; i++) begin
            e.word = cur_blk[BW-1-i*W -: W];
            e.last = (i == WPB - 1);
            exp_q.push_back(e);
          end
        end
        total++;
        if (empty !== (model_count == 0) || full !== (model_count == D)) begin
          bad++;
          $display("[TB] FAIL flags: empty=%0b full=%0b required empty=%0b full=%0b",
                   empty, full, model_count == 0, model_count == D);
        end
        if (wordValid) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL word_unexpected: wordOut=%h with no word outstanding", wordOut);
          end else begin
            if (wordOut !== exp_q[0].word || wordLast !== exp_q[0].last) begin
              bad++;
              $display("[TB] FAIL word: wordOut=%h wordLast=%0b required %h/%0b",
                       wordOut, wordLast, exp_q[0].word, exp_q[0].last);
            end
`ifdef SIMON_SER_PARITY_EN
            total++;
            if (wordPar !== ^exp_q[0].word) begin
              bad++;
              $display("[TB] FAIL parity: wordPar=%0b required %0b", wordPar, ^exp_q[0].word);
            end
`endif
            if (wordReady) begin
              e = exp_q.pop_front();
              pending_pop = e.last;
              mid_block = !e.last;
            end
          end
        end else begin
          total++;
          if (mid_block || wordLast) begin
            bad++;
            $display("[TB] FAIL valid_gap: wordValid=0 wordLast=%0b mid_block=%0b required valid held", wordLast, mid_block);
          end
        end
        prev_rd = readData;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_block(input logic [BW-1:0] blk, input int budget);
    int n;
    n = 0;
    if (readData) step();
    cur_blk = blk;
    outData = blk;
    doneData = 1'b1;
    do begin
      step();
      n++;
    end while (!readData && n < budget);
    total++;
    if (!readData) begin
      bad++;
      $display("[TB] FAIL capture_timeout: readData=%0b required 1 within %0d cycles", readData, budget);
    end
    doneData = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!wordValid && n < budget) begin
      step();
      n++;
    end
    total++;
    if (!wordValid) begin
      bad++;
      $display("[TB] FAIL valid_timeout: wordValid=%0b required 1 within %0d cycles", wordValid, budget);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty || wordValid) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || !empty || wordValid) begin
      bad++;
      $display("[TB] FAIL drain_timeout: pending=%0d empty=%0b required 0/1", exp_q.size(), empty);
    end
  endtask

  task automatic test_reset();
    logic [BW-1:0] blk;
    blk = {$urandom, $urandom, $urandom, $urandom};
    nR = 1'b0;
    wordReady = 1'b1;
    cur_blk = blk;
    outData = blk;
    doneData = 1'b1;
    repeat (3) step();
    total++;
    if (readData !== 1'b0 || wordValid !== 1'b0 || wordLast !== 1'b0 || wordOut !== '0 ||
        empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_values: rd=%0b vld=%0b last=%0b out=%h empty=%0b full=%0b required 0/0/0/0/1/0",
               readData, wordValid, wordLast, wordOut, empty, full);
    end
`ifdef SIMON_SER_PARITY_EN
    total++;
    if (wordPar !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_parity: wordPar=%0b required 0", wordPar);
    end
`endif
    nR = 1'b1;
    total++;
    if (readData !== 1'b0) begin
      bad++;
      $display("[TB] FAIL release_rd: readData=%0b required 0", readData);
    end
    step();
    total++;
    if (readData !== 1'b1 || empty !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_capture: readData=%0b empty=%0b required 1/0", readData, empty);
    end
    doneData = 1'b0;
    step();
    total++;
    if (readData !== 1'b0 || wordValid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL first_word_latency: readData=%0b wordValid=%0b required 0/1", readData, wordValid);
    end
    wait_drain(40);
  endtask

  task automatic test_single();
    logic [BW-1:0] blk;
    logic [W-1:0]  ref_words [WPB];
    blk = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    ref_words = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
    wordReady = 1'b1;
    offer_block(blk, 20);
    wait_valid(10);
    for (int i = 0; i < WPB; i++) begin
      total++;
      if (wordValid !== 1'b1 || wordOut !== ref_words[i] || wordLast !== (i == WPB - 1)) begin
        bad++;
        $display("[TB] FAIL single_word%0d: vld=%0b out=%h last=%0b required 1/%h/%0b",
                 i, wordValid, wordOut, wordLast, ref_words[i], i == WPB - 1);
      end
      step();
    end
    total++;
    if (wordValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_gap: wordValid=%0b required 0 after last word", wordValid);
    end
    wait_drain(20);
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] blk;
    logic [W-1:0]  held;
    blk = {$urandom, $urandom, $urandom, $urandom};
    held = blk[BW-1-2*W -: W];
    wordReady = 1'b1;
    offer_block(blk, 20);
    wait_valid(10);
    step();
    step();
    wordReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (wordValid !== 1'b1 || wordOut !== held || wordLast !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d: vld=%0b out=%h last=%0b required 1/%h/0",
                 i, wordValid, wordOut, wordLast, held);
      end
      step();
    end
    wordReady = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_full();
    int rd_before;
    rd_before = rd_count;
    wordReady = 1'b0;
    offer_block({$urandom, $urandom, $urandom, $urandom}, 20);
    offer_block({$urandom, $urandom, $urandom, $urandom}, 20);
    total++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_flag: full=%0b empty=%0b required 1/0", full, empty);
    end
    step();
    fork
      offer_block({$urandom, $urandom, $urandom, $urandom}, 100);
      begin
        for (int i = 0; i < 6; i++) begin
          total++;
          if (readData !== 1'b0 || full !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_hold%0d: readData=%0b full=%0b required 0/1", i, readData, full);
          end
          step();
        end
        wordReady = 1'b1;
      end
    join
    wait_drain(60);
    total++;
    if (rd_count - rd_before != 3) begin
      bad++;
      $display("[TB] FAIL full_pulses: readData pulses=%0d required 3", rd_count - rd_before);
    end
  endtask

  task automatic test_simultaneous();
    logic [BW-1:0] blk_b;
    int n;
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    wordReady = 1'b1;
    offer_block({$urandom, $urandom, $urandom, $urandom}, 20);
    n = 0;
    while (!(wordValid && wordLast) && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!(wordValid && wordLast)) begin
      bad++;
      $display("[TB] FAIL simul_last_timeout: wordLast=%0b required 1", wordLast);
    end
    cur_blk = blk_b;
    outData = blk_b;
    doneData = 1'b1;
    step();
    doneData = 1'b0;
    total++;
    if (readData !== 1'b1 || empty !== 1'b0 || full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL simul_count: readData=%0b empty=%0b full=%0b required 1/0/0", readData, empty, full);
    end
    wait_valid(10);
    total++;
    if (wordOut !== blk_b[BW-1 -: W]) begin
      bad++;
      $display("[TB] FAIL simul_order: wordOut=%h required %h", wordOut, blk_b[BW-1 -: W]);
    end
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] blk_a;
    logic [BW-1:0] blk_c;
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_c = {$urandom, $urandom, $urandom, $urandom};
    wordReady = 1'b1;
    offer_block(blk_a, 20);
    offer_block({$urandom, $urandom, $urandom, $urandom}, 20);
    step();
    total++;
    if (wordValid !== 1'b1 || wordOut !== blk_a[BW-1-2*W -: W]) begin
      bad++;
      $display("[TB] FAIL mid_word2: vld=%0b out=%h required 1/%h", wordValid, wordOut, blk_a[BW-1-2*W -: W]);
    end
    nR = 1'b0;
    step();
    total++;
    if (wordValid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || readData !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset: vld=%0b empty=%0b full=%0b rd=%0b required 0/1/0/0",
               wordValid, empty, full, readData);
    end
    step();
    nR = 1'b1;
    step();
    offer_block(blk_c, 20);
    wait_valid(10);
    total++;
    if (wordOut !== blk_c[BW-1 -: W] || wordLast !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_word0: out=%h last=%0b required %h/0", wordOut, wordLast, blk_c[BW-1 -: W]);
    end
    wait_drain(20);
  endtask

  task automatic test_random();
    int rd_before;
    int nblk;
    rd_before = rd_count;
    nblk = 16;
    fork
      begin
        for (int i = 0; i < nblk; i++) begin
          repeat ($urandom_range(0, 3)) step();
          offer_block({$urandom, $urandom, $urandom, $urandom}, 200);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while ((rd_count - rd_before < nblk || exp_q.size() != 0) && cyc < 3000) begin
          wordReady = ($urandom_range(0, 1) == 1);
          step();
          cyc++;
        end
        wordReady = 1'b1;
      end
    join
    wait_drain(100);
    total++;
    if (rd_count - rd_before != nblk) begin
      bad++;
      $display("[TB] FAIL random_pulses: readData pulses=%0d required %0d", rd_count - rd_before, nblk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_simultaneous();
    test_reset_mid();
    test_random();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
